// File: rtl/ctrl_pkg.sv
// Shared encodings and control-bundle types for the RV32I pipelined control unit.
package ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_e;

   typedef enum logic [1:0] {
      ASRC_RS2 = 2'b00,
      ASRC_IMM = 2'b01,
      ASRC_PC  = 2'b10
   } alu_src_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } result_src_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_e;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        jalr;
      alu_src_e    alu_src;
      alu_ctrl_e   alu_ctrl;
      result_src_e result_src;
   } ex_ctrl_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      result_src_e result_src;
   } mem_ctrl_t;

   typedef struct packed {
      logic        reg_write;
      result_src_e result_src;
   } wb_ctrl_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-stage decode inputs, hazard controls and per-stage control outputs.
interface ctrl_pipe_if #(
   parameter int unsigned CNT_W = 8
);
   logic [6:0]       op;
   logic [2:0]       funct3;
   logic             funct7b5;
   logic             stall_e;
   logic             flush_e;
   logic [2:0]       ImmSrcD;
   logic             illegal_d;
   logic             RegWriteE;
   logic             MemWriteE;
   logic             BranchE;
   logic             JumpE;
   logic             JalrE;
   logic [1:0]       ALUSrcE;
   logic [2:0]       ALUControlE;
   logic [1:0]       ResultSrcE;
   logic             RegWriteM;
   logic             MemWriteM;
   logic [1:0]       ResultSrcM;
   logic             RegWriteW;
   logic [1:0]       ResultSrcW;
   logic [CNT_W-1:0] illegal_cnt;

   modport master (
      output op, funct3, funct7b5, stall_e, flush_e,
      input  ImmSrcD, illegal_d,
      input  RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, ALUControlE, ResultSrcE,
      input  RegWriteM, MemWriteM, ResultSrcM,
      input  RegWriteW, ResultSrcW,
      input  illegal_cnt
   );

   modport slave (
      input  op, funct3, funct7b5, stall_e, flush_e,
      output ImmSrcD, illegal_d,
      output RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, ALUControlE, ResultSrcE,
      output RegWriteM, MemWriteM, ResultSrcM,
      output RegWriteW, ResultSrcW,
      output illegal_cnt
   );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational main + ALU decode; U-type and JALR support gated by parameters.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter bit SUPPORT_U    = 1'b1,
   parameter bit SUPPORT_JALR = 1'b1
) (
   input  logic [6:0] i_op,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   output ex_ctrl_t   o_ctrl,
   output imm_src_e   o_imm_src,
   output logic       o_illegal
);

   ex_ctrl_t w_ctrl;
   imm_src_e w_imm;
   alu_op_e  w_alu_op;
   logic     w_illegal;

   always_comb begin
      w_ctrl    = '0;
      w_imm     = IMM_I;
      w_alu_op  = ALUOP_ADD;
      w_illegal = 1'b0;
      case (i_op)
         OP_LOAD: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.alu_src    = ASRC_IMM;
            w_ctrl.result_src = RES_MEM;
         end
         OP_STORE: begin
            w_ctrl.mem_write = 1'b1;
            w_imm            = IMM_S;
            w_ctrl.alu_src   = ASRC_IMM;
         end
         OP_R: begin
            w_ctrl.reg_write = 1'b1;
            w_alu_op         = ALUOP_FUNCT;
         end
         OP_I: begin
            w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_src   = ASRC_IMM;
            w_alu_op         = ALUOP_FUNCT;
         end
         OP_BRANCH: begin
            w_ctrl.branch = 1'b1;
            w_imm         = IMM_B;
            w_alu_op      = ALUOP_SUB;
         end
         OP_JAL: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.jump       = 1'b1;
            w_imm             = IMM_J;
            w_ctrl.result_src = RES_PC4;
         end
         OP_JALR: begin
            if (SUPPORT_JALR) begin
               w_ctrl.reg_write  = 1'b1;
               w_ctrl.jump       = 1'b1;
               w_ctrl.jalr       = 1'b1;
               w_ctrl.alu_src    = ASRC_IMM;
               w_ctrl.result_src = RES_PC4;
            end else begin
               w_illegal = 1'b1;
            end
         end
         OP_LUI: begin
            if (SUPPORT_U) begin
               w_ctrl.reg_write  = 1'b1;
               w_imm             = IMM_U;
               w_ctrl.result_src = RES_IMM;
            end else begin
               w_illegal = 1'b1;
            end
         end
         OP_AUIPC: begin
            if (SUPPORT_U) begin
               w_ctrl.reg_write = 1'b1;
               w_imm            = IMM_U;
               w_ctrl.alu_src   = ASRC_PC;
            end else begin
               w_illegal = 1'b1;
            end
         end
         default: w_illegal = 1'b1;
      endcase

      // op[5] separates R-type from I-type: only R-type honours funct7b5 for sub
      case (w_alu_op)
         ALUOP_SUB: w_ctrl.alu_ctrl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct3)
               3'b000:  w_ctrl.alu_ctrl = (i_op[5] && i_funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  w_ctrl.alu_ctrl = ALU_SLT;
               3'b110:  w_ctrl.alu_ctrl = ALU_OR;
               3'b111:  w_ctrl.alu_ctrl = ALU_AND;
               default: w_ctrl.alu_ctrl = ALU_ADD;
            endcase
         end
         default: w_ctrl.alu_ctrl = ALU_ADD;
      endcase
   end

   always_comb begin
      o_ctrl    = w_ctrl;
      o_imm_src = w_imm;
      o_illegal = w_illegal;
      if (w_illegal) begin
         o_ctrl    = '0;
         o_imm_src = IMM_I;
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: ID decode carried through ID/EX, EX/MEM and MEM/WB,
// with flush/stall on ID/EX and a saturating count of illegal opcodes entering EX.
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter bit          SUPPORT_U    = 1'b1,
   parameter bit          SUPPORT_JALR = 1'b1,
   parameter int unsigned CNT_W        = 8
) (
   input  logic           clk,
   input  logic           rst,
   ctrl_pipe_if.slave     bus
);

   ex_ctrl_t         w_dec;
   imm_src_e         w_imm;
   logic             w_illegal;
   logic             w_load;

   ex_ctrl_t         r_e;
   mem_ctrl_t        r_m;
   wb_ctrl_t         r_w;
   logic [CNT_W-1:0] r_cnt;

   ctrl_decode #(
      .SUPPORT_U    (SUPPORT_U),
      .SUPPORT_JALR (SUPPORT_JALR)
   ) u_decode (
      .i_op       (bus.op),
      .i_funct3   (bus.funct3),
      .i_funct7b5 (bus.funct7b5),
      .o_ctrl     (w_dec),
      .o_imm_src  (w_imm),
      .o_illegal  (w_illegal)
   );

   assign w_load = !bus.flush_e && !bus.stall_e;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_e   <= '0;
         r_m   <= '0;
         r_w   <= '0;
         r_cnt <= '0;
      end else begin
         if (bus.flush_e) begin
            r_e <= '0;
         end else if (!bus.stall_e) begin
            r_e <= w_dec;
         end
         r_m <= '{reg_write: r_e.reg_write, mem_write: r_e.mem_write, result_src: r_e.result_src};
         r_w <= '{reg_write: r_m.reg_write, result_src: r_m.result_src};
         if (w_load && w_illegal && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.ImmSrcD     = w_imm;
   assign bus.illegal_d   = w_illegal;
   assign bus.RegWriteE   = r_e.reg_write;
   assign bus.MemWriteE   = r_e.mem_write;
   assign bus.BranchE     = r_e.branch;
   assign bus.JumpE       = r_e.jump;
   assign bus.JalrE       = r_e.jalr;
   assign bus.ALUSrcE     = r_e.alu_src;
   assign bus.ALUControlE = r_e.alu_ctrl;
   assign bus.ResultSrcE  = r_e.result_src;
   assign bus.RegWriteM   = r_m.reg_write;
   assign bus.MemWriteM   = r_m.mem_write;
   assign bus.ResultSrcM  = r_m.result_src;
   assign bus.RegWriteW   = r_w.reg_write;
   assign bus.ResultSrcW  = r_w.result_src;
   assign bus.illegal_cnt = r_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: one full-featured instance and one with U/JALR disabled and a 2-bit counter.
module tb_ctrl_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] t_op     = '0;
   logic [2:0] t_f3     = '0;
   logic       t_f7     = 1'b0;
   logic       t_stall  = 1'b0;
   logic       t_flush  = 1'b0;
   logic       t_rst    = 1'b0;

   ctrl_pipe_if #(.CNT_W(8)) if_a ();
   ctrl_pipe_if #(.CNT_W(2)) if_b ();

   assign if_a.op = t_op;  assign if_a.funct3 = t_f3;  assign if_a.funct7b5 = t_f7;
   assign if_a.stall_e = t_stall;  assign if_a.flush_e = t_flush;
   assign if_b.op = t_op;  assign if_b.funct3 = t_f3;  assign if_b.funct7b5 = t_f7;
   assign if_b.stall_e = t_stall;  assign if_b.flush_e = t_flush;

   ctrl_pipe #(.SUPPORT_U(1'b1), .SUPPORT_JALR(1'b1), .CNT_W(8)) u_dut_a (
      .clk (clk), .rst (t_rst), .bus (if_a.slave)
   );
   ctrl_pipe #(.SUPPORT_U(1'b0), .SUPPORT_JALR(1'b0), .CNT_W(2)) u_dut_b (
      .clk (clk), .rst (t_rst), .bus (if_b.slave)
   );

   // E bundle layout: rw mw br jp jr as[2] al[3] rs[2]; M: rw mw rs[2]; W: rw rs[2]
   logic [1:0][11:0] obs_e;
   logic [1:0][3:0]  obs_m;
   logic [1:0][2:0]  obs_w;
   logic [1:0][7:0]  obs_c;
   logic [1:0][2:0]  obs_imm;
   logic [1:0]       obs_ill;

   assign obs_e[0] = {if_a.RegWriteE, if_a.MemWriteE, if_a.BranchE, if_a.JumpE, if_a.JalrE,
                      if_a.ALUSrcE, if_a.ALUControlE, if_a.ResultSrcE};
   assign obs_e[1] = {if_b.RegWriteE, if_b.MemWriteE, if_b.BranchE, if_b.JumpE, if_b.JalrE,
                      if_b.ALUSrcE, if_b.ALUControlE, if_b.ResultSrcE};
   assign obs_m[0] = {if_a.RegWriteM, if_a.MemWriteM, if_a.ResultSrcM};
   assign obs_m[1] = {if_b.RegWriteM, if_b.MemWriteM, if_b.ResultSrcM};
   assign obs_w[0] = {if_a.RegWriteW, if_a.ResultSrcW};
   assign obs_w[1] = {if_b.RegWriteW, if_b.ResultSrcW};
   assign obs_c[0] = if_a.illegal_cnt;
   assign obs_c[1] = {6'b0, if_b.illegal_cnt};
   assign obs_imm[0] = if_a.ImmSrcD;
   assign obs_imm[1] = if_b.ImmSrcD;
   assign obs_ill[0] = if_a.illegal_d;
   assign obs_ill[1] = if_b.illegal_d;

   int n_checks = 0;
   int n_errors = 0;

   bit          su_p [2] = '{1'b1, 1'b0};
   bit          sj_p [2] = '{1'b1, 1'b0};
   int unsigned cmax [2] = '{255, 3};

   logic [11:0] me  [2];
   logic [3:0]  mm  [2];
   logic [2:0]  mwb [2];
   int unsigned mc  [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] funct_alu(input logic [2:0] f, input logic is_sub);
      case (f)
         3'b000:  return is_sub ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Reference decode built from the instruction-class table
   function automatic void ref_dec(input logic [6:0] o, input logic [2:0] f, input logic b7,
                                   input bit su, input bit sj,
                                   output logic [11:0] e, output logic [2:0] imm, output logic ill);
      logic rw, mw, br, jp, jr;
      logic [1:0] as, rs;
      logic [2:0] al;
      string alu;
      rw = 1'b0; mw = 1'b0; br = 1'b0; jp = 1'b0; jr = 1'b0;
      as = 2'd0; rs = 2'd0; imm = 3'd0; ill = 1'b0; alu = "add";
      case (o)
         7'b0000011: begin rw = 1'b1; as = 2'd1; rs = 2'd1; end
         7'b0100011: begin mw = 1'b1; imm = 3'd1; as = 2'd1; end
         7'b0110011: begin rw = 1'b1; alu = "funct"; end
         7'b0010011: begin rw = 1'b1; as = 2'd1; alu = "funct"; end
         7'b1100011: begin br = 1'b1; imm = 3'd2; alu = "sub"; end
         7'b1101111: begin rw = 1'b1; jp = 1'b1; imm = 3'd3; rs = 2'd2; end
         7'b1100111: if (sj) begin rw = 1'b1; jp = 1'b1; jr = 1'b1; as = 2'd1; rs = 2'd2; end
                     else ill = 1'b1;
         7'b0110111: if (su) begin rw = 1'b1; imm = 3'd4; rs = 2'd3; end
                     else ill = 1'b1;
         7'b0010111: if (su) begin rw = 1'b1; imm = 3'd4; as = 2'd2; end
                     else ill = 1'b1;
         default:    ill = 1'b1;
      endcase
      if (alu == "sub")        al = 3'b001;
      else if (alu == "funct") al = funct_alu(f, o[5] & b7);
      else                     al = 3'b000;
      if (ill) begin
         e   = '0;
         imm = 3'd0;
      end else begin
         e = {rw, mw, br, jp, jr, as, al, rs};
      end
   endfunction

   task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic b7,
                        input logic s, input logic fl, input logic r);
      logic [11:0] e;
      logic [2:0]  imm;
      logic        ill;
      t_op = o; t_f3 = f; t_f7 = b7; t_stall = s; t_flush = fl; t_rst = r;
      #1;
      for (int k = 0; k < 2; k++) begin
         ref_dec(t_op, t_f3, t_f7, su_p[k], sj_p[k], e, imm, ill);
         check($sformatf("imm%0d", k), 32'(obs_imm[k]), 32'(imm));
         check($sformatf("ill%0d", k), 32'(obs_ill[k]), 32'(ill));
      end
   endtask

   task automatic clock();
      logic [11:0] e;
      logic [2:0]  imm;
      logic        ill;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!t_rst) begin
            me[k] = '0; mm[k] = '0; mwb[k] = '0; mc[k] = 0;
         end else begin
            ref_dec(t_op, t_f3, t_f7, su_p[k], sj_p[k], e, imm, ill);
            mwb[k] = {mm[k][3], mm[k][1:0]};
            mm[k]  = {me[k][11], me[k][10], me[k][1:0]};
            if (t_flush)      me[k] = '0;
            else if (!t_stall) me[k] = e;
            if (!t_flush && !t_stall && ill && mc[k] < cmax[k]) mc[k]++;
         end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("E%0d", k),   32'(obs_e[k]), 32'(me[k]));
         check($sformatf("M%0d", k),   32'(obs_m[k]), 32'(mm[k]));
         check($sformatf("W%0d", k),   32'(obs_w[k]), 32'(mwb[k]));
         check($sformatf("CNT%0d", k), 32'(obs_c[k]), mc[k]);
      end
   endtask

   task automatic step(input logic [6:0] o, input logic [2:0] f, input logic b7,
                       input logic s, input logic fl, input logic r);
      drive(o, f, b7, s, fl, r);
      clock();
   endtask

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic        stall;
      logic        flush;
      logic [2:0]  imm;
      logic [11:0] e;
   } vec_t;

   vec_t tbl [17];
   logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

   localparam logic [11:0] E_LOAD  = 12'b1_0_0_0_0_01_000_01;
   localparam logic [11:0] E_STORE = 12'b0_1_0_0_0_01_000_00;

   initial begin
      // Expected E bundle / ImmSrcD for the full-featured instance
      tbl[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, E_LOAD};
      tbl[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 12'b1_0_0_0_0_00_001_00};
      tbl[2]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 12'b1_0_0_0_0_01_000_00};
      tbl[3]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 12'b1_0_0_0_0_00_010_00};
      tbl[4]  = '{7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 12'b1_0_0_0_0_00_000_11};
      tbl[5]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b001, E_STORE};
      tbl[6]  = '{7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b010, 12'b0_0_1_0_0_00_001_00};
      tbl[7]  = '{7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b011, 12'b1_0_0_1_0_00_000_10};
      tbl[8]  = '{7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 12'b1_0_0_1_1_01_000_10};
      tbl[9]  = '{7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 12'b1_0_0_0_0_10_000_00};
      tbl[10] = '{7'b0010011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 12'b1_0_0_0_0_01_101_00};
      tbl[11] = '{7'b0010011, 3'b110, 1'b0, 1'b0, 1'b0, 3'b000, 12'b1_0_0_0_0_01_011_00};
      tbl[12] = '{7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 12'b1_0_0_0_0_00_000_00};
      tbl[13] = '{7'b1100111, 3'b000, 1'b0, 1'b1, 1'b1, 3'b000, 12'b0};
      tbl[14] = '{7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 12'b0};
      tbl[15] = '{7'b0100011, 3'b000, 1'b1, 1'b0, 1'b0, 3'b001, E_STORE};
      tbl[16] = '{7'b1100011, 3'b111, 1'b0, 1'b0, 1'b0, 3'b010, 12'b0_0_1_0_0_00_001_00};

      // Reset held for two cycles, flush asserted alongside
      step(7'b0000011, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
      step(7'b0000011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_E", 32'(obs_e[0]), 32'h0);
      check("rst_cnt", 32'(obs_c[0]), 32'h0);

      // Load latency: E after 1 edge, W after 3
      step(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
      check("load_E", 32'(obs_e[0]), 32'(E_LOAD));
      step(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      step(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      check("load_W", 32'(obs_w[0]), 32'(3'b101));

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].stall, tbl[i].flush, 1'b1);
         check($sformatf("tbl%0d_imm", i), 32'(obs_imm[0]), 32'(tbl[i].imm));
         clock();
         check($sformatf("tbl%0d_E", i), 32'(obs_e[0]), 32'(tbl[i].e));
      end

      // LUI on the U-disabled instance is illegal and counted
      step(7'b0000011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      check("b_lui_ill", 32'(obs_ill[1]), 32'h1);
      check("a_lui_imm", 32'(obs_imm[0]), 32'(3'b100));
      clock();
      check("b_lui_E", 32'(obs_e[1]), 32'h0);
      check("b_lui_cnt", 32'(obs_c[1]), 32'h1);
      check("a_lui_E", 32'(obs_e[0]), 32'(12'b1_0_0_0_0_00_000_11));

      // Stall after a load, then after a store: E held, M copies held bundle
      step(7'b0000011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         step(7'b0100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
         check("stall_ld_E", 32'(obs_e[0]), 32'(E_LOAD));
         check("stall_ld_MW", 32'(obs_m[0][2]), 32'h0);
      end
      step(7'b0100011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         step(7'b0000011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
         check("stall_st_E", 32'(obs_e[0]), 32'(E_STORE));
         check("stall_st_MW", 32'(obs_m[0][2]), 32'h1);
      end

      // Counter saturation on the 2-bit instance
      step(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      check("sat_b", 32'(obs_c[1]), 32'h3);
      check("sat_a", 32'(obs_c[0]), 32'h5);

      // Reset mid-stream clears every stage at once
      step(7'b0000011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      step(7'b0100011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      step(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
      step(7'b0000011, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("mid_rst_E%0d", k), 32'(obs_e[k]), 32'h0);
         check($sformatf("mid_rst_M%0d", k), 32'(obs_m[k]), 32'h0);
         check($sformatf("mid_rst_W%0d", k), 32'(obs_w[k]), 32'h0);
         check($sformatf("mid_rst_C%0d", k), 32'(obs_c[k]), 32'h0);
      end

      for (int i = 0; i < 400; i++) begin
         logic [6:0] o;
         if ($urandom_range(0, 9) == 0) o = 7'($urandom);
         else o = ops[$urandom_range(0, 8)];
         step(o, 3'($urandom), 1'($urandom),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 29) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
